cell_pixel_generator: RTL and testbench
=======================================

# cell_pixel_generator

Parametrised cell-based pixel generator that turns the VGA timing strobes into 12-bit RGB output from a writable cell framebuffer and a writable palette. It sits between the VGA timing generator and the DAC pins and consumes the 32-bit instruction stream from the command decoder. Each framebuffer cell covers CELL_W × CELL_H screen dots. Background colour and palette-0 substitution are frame-synchronous, and a hardware CLEAR fills the buffer without host involvement.

## Interface
- GRID_W, 40, cells per row (1..256)
- GRID_H, 30, cell rows (1..256)
- CELL_W, 16, dots per cell horizontally (1..64)
- CELL_H, 16, lines per cell vertically (1..64)
- BPP, 3, bits per cell (1..4); palette depth = 2**BPP
- i_clk  in  1  pixel clock
- i_reset  in  1  asynchronous, active-high reset
- i_vsync  in  1  one-cycle pulse at frame start
- i_hsync  in  1  one-cycle pulse after every line
- i_pixel_valid  in  1  dot is inside the visible area
- i_instruction  in  32  [7:0] opcode, [31:8] args
- i_instruction_ready  in  1  instruction valid this cycle
- o_color  out  12  RGB444 output
- o_color_valid  out  1  o_color corresponds to a visible dot
- o_busy  out  1  CLEAR in progress
- o_dropped  out  1  one-cycle pulse when an instruction is rejected

## Operation
- Opcodes, executed the cycle after i_instruction_ready:
  - 0x01 SET_BG_COLOR: pending_bg ← args[11:0].
  - 0x07 SET_PIXEL: cell[args[15:0]] ← args[16+BPP-1:16].
  - 0x08 SET_PALETTE: palette[args[15:12] mod 2**BPP] ← args[11:0]; takes effect immediately.
  - 0x09 CLEAR: writes args[16+BPP-1:16] to every cell, index 0 up to GRID_W*GRID_H-1, one cell per cycle; o_busy is high for the whole sweep.
  - Any other opcode is ignored, with no drop pulse.
- Rejects: SET_PIXEL with index ≥ GRID_W*GRID_H; SET_PIXEL or CLEAR while o_busy. Each reject raises o_dropped for 1 cycle and leaves the buffer unchanged. SET_BG_COLOR and SET_PALETTE are always accepted.
- i_vsync: bg_color ← pending_bg, and all position counters go to 0.
- Horizontal position:
  - Each i_pixel_valid cycle advances x_sub. When x_sub wraps at CELL_W-1, cell_x increments, saturating at GRID_W.
  - i_hsync clears x_sub and cell_x.
- Vertical position:
  - On i_hsync after a line that contained at least one valid dot, y_sub advances. When y_sub wraps at CELL_H-1, cell_y increments (saturating at GRID_H) and row_base += GRID_W.
- Colour:
  - Cell value 0 shows bg_color; any other value v shows palette[v].
  - A dot with cell_x ≥ GRID_W or cell_y ≥ GRID_H shows bg_color.
  - A non-visible dot outputs 12'h000 with o_color_valid = 0.
- Reset values: o_color = 0, o_color_valid = 0, o_busy = 0, o_dropped = 0, bg_color = pending_bg = 12'h000, all counters 0.
- Palette reset: 000, fff, f00, 0f0, 00f, f0f, 0ff, ff0, then entries 8–15 = 000.
- Framebuffer contents are undefined after reset. Software issues CLEAR.
- Reset asserted mid-CLEAR aborts the sweep and drops o_busy asynchronously.

## Timing
- Instruction path: 1 cycle input register, then execute. A write is visible to the read port from the following cycle.
- Pixel path: 2 cycles from i_pixel_valid to o_color / o_color_valid.
  - Stage 1: registered RAM read at row_base + cell_x.
  - Stage 2: palette/bg select.
- Same-cycle RAM read and write to the same cell returns the old data (read-first).
- i_vsync and i_hsync in the same cycle: both resets apply.
- CLEAR costs GRID_W*GRID_H cycles. o_busy rises the cycle after acceptance and falls the cycle after the last write.

## Structure
- Package pixgen_pkg holds:
  - opcode localparams
  - the default palette constant
  - the RGB444 type
  - a function computing clog2-based address width from GRID_W*GRID_H
- Sub-module cell_buffer_ram: simple dual-port RAM, 1 write port and 1 registered read port, depth GRID_W*GRID_H, width BPP, no reset.

## Test plan
- Reset, then CLEAR value 0, then SET_BG_COLOR 0x0a5 + vsync -> every visible dot = 12'h0a5 with o_color_valid; o_busy high for exactly 1200 cycles (40×30).
- SET_PIXEL index 41, value 2 -> dots x 16..31, lines 16..31 = 12'hf00; all other dots = bg.
- SET_PALETTE entry 2 ← 0x123 mid-frame -> later dots of cell 41 = 12'h123 without waiting for vsync.
- SET_PIXEL index 1200, and SET_PIXEL during CLEAR -> o_dropped pulses once each; buffer unchanged.
- SET_BG_COLOR 0xfff mid-frame -> old bg persists until the next i_vsync, then 12'hfff.
- Assert i_reset mid-CLEAR -> o_busy = 0 and o_color = 0 immediately; palette reads back the defaults.

Source files
------------

// File: rtl/pixgen_pkg.sv
// Shared types, opcodes and sizing helpers for the cell-based pixel generator.
package pixgen_pkg;

    typedef logic [11:0] rgb444_t;

    localparam logic [7:0] OP_SET_BG_COLOR = 8'h01;
    localparam logic [7:0] OP_SET_PIXEL    = 8'h07;
    localparam logic [7:0] OP_SET_PALETTE  = 8'h08;
    localparam logic [7:0] OP_CLEAR        = 8'h09;

    localparam int PALETTE_MAX = 16;

    // Entry i lives at bits [i*12 +: 12]; entry 0 is the rightmost literal.
    localparam logic [PALETTE_MAX*12-1:0] DEFAULT_PALETTE = {
        12'h000, 12'h000, 12'h000, 12'h000,
        12'h000, 12'h000, 12'h000, 12'h000,
        12'hff0, 12'h0ff, 12'hf0f, 12'h00f,
        12'h0f0, 12'hf00, 12'hfff, 12'h000
    };

    typedef enum logic {
        SWEEP_IDLE  = 1'b0,
        SWEEP_CLEAR = 1'b1
    } sweep_state_e;

    function automatic int count_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int addr_width(input int grid_w, input int grid_h);
        return count_width(grid_w * grid_h - 1);
    endfunction

endpackage

// File: rtl/cell_buffer_ram.sv
// Simple dual-port cell store: one write port, one registered read-first read port.
module cell_buffer_ram #(
    parameter int DEPTH  = 1200,
    parameter int WIDTH  = 3,
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: no reset on the array so it maps onto block RAM; software fills it with CLEAR.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cell_pixel_generator.sv
// Turns VGA timing strobes into RGB444 dots from a cell framebuffer and palette,
// executing SET_BG_COLOR / SET_PIXEL / SET_PALETTE / CLEAR from the command stream.
module cell_pixel_generator
    import pixgen_pkg::*;
#(
    parameter int GRID_W = 40,
    parameter int GRID_H = 30,
    parameter int CELL_W = 16,
    parameter int CELL_H = 16,
    parameter int BPP    = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_vsync,
    input  logic        i_hsync,
    input  logic        i_pixel_valid,
    input  logic [31:0] i_instruction,
    input  logic        i_instruction_ready,
    output logic [11:0] o_color,
    output logic        o_color_valid,
    output logic        o_busy,
    output logic        o_dropped
);

    localparam int DEPTH  = GRID_W * GRID_H;
    localparam int ADDR_W = addr_width(GRID_W, GRID_H);
    localparam int PAL_N  = 1 << BPP;
    localparam int XS_W   = count_width(CELL_W - 1);
    localparam int YS_W   = count_width(CELL_H - 1);
    localparam int CX_W   = count_width(GRID_W);
    localparam int CY_W   = count_width(GRID_H);
    localparam int RB_W   = count_width(DEPTH);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [16:0]       DEPTH_LIM = 17'(DEPTH);

    // ---------------- instruction register and decode ----------------
    logic [31:0]    instr_q;
    logic           instr_vld_q;
    logic [7:0]     opcode;
    logic [15:0]    cmd_index;
    logic [BPP-1:0] cmd_value;
    logic [BPP-1:0] cmd_pal_idx;
    rgb444_t        cmd_color;
    logic           unused_instr;

    assign opcode       = instr_q[7:0];
    assign cmd_color    = instr_q[19:8];
    assign cmd_pal_idx  = instr_q[20 +: BPP];
    assign cmd_index    = instr_q[23:8];
    assign cmd_value    = instr_q[24 +: BPP];
    assign unused_instr = &{1'b0, instr_q[31:24+BPP]};

    sweep_state_e    state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [BPP-1:0]  clr_val_q, clr_val_d;
    logic            busy;
    logic            start_clear;
    logic            pix_we;
    logic            reject;

    assign busy = (state_q == SWEEP_CLEAR);

    always_comb begin
        start_clear = 1'b0;
        pix_we      = 1'b0;
        reject      = 1'b0;
        if (instr_vld_q) begin
            case (opcode)
                OP_SET_PIXEL: begin
                    if (busy || ({1'b0, cmd_index} >= DEPTH_LIM)) reject = 1'b1;
                    else                                          pix_we = 1'b1;
                end
                OP_CLEAR: begin
                    if (busy) reject      = 1'b1;
                    else      start_clear = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // CLEAR sweep: one cell per cycle, leaving on the cycle the last cell is written.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_val_d  = clr_val_q;
        case (state_q)
            SWEEP_IDLE: begin
                if (start_clear) begin
                    state_d    = SWEEP_CLEAR;
                    clr_addr_d = '0;
                    clr_val_d  = cmd_value;
                end
            end
            SWEEP_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) state_d = SWEEP_IDLE;
            end
            default: state_d = SWEEP_IDLE;
        endcase
    end

    rgb444_t        pending_bg_q, bg_q;
    rgb444_t        palette_q [PAL_N];
    logic           dropped_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            instr_q      <= '0;
            instr_vld_q  <= 1'b0;
            state_q      <= SWEEP_IDLE;
            clr_addr_q   <= '0;
            clr_val_q    <= '0;
            pending_bg_q <= '0;
            bg_q         <= '0;
            dropped_q    <= 1'b0;
            for (int i = 0; i < PAL_N; i++) begin
                palette_q[i] <= DEFAULT_PALETTE[i*12 +: 12];
            end
        end else begin
            instr_q     <= i_instruction;
            instr_vld_q <= i_instruction_ready;
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            clr_val_q   <= clr_val_d;
            dropped_q   <= reject;
            if (instr_vld_q && opcode == OP_SET_BG_COLOR) pending_bg_q <= cmd_color;
            if (instr_vld_q && opcode == OP_SET_PALETTE)  palette_q[cmd_pal_idx] <= cmd_color;
            if (i_vsync) bg_q <= pending_bg_q;
        end
    end

    // ---------------- raster position ----------------
    logic [XS_W-1:0] x_sub_q, x_sub_d;
    logic [YS_W-1:0] y_sub_q, y_sub_d;
    logic [CX_W-1:0] cell_x_q, cell_x_d;
    logic [CY_W-1:0] cell_y_q, cell_y_d;
    logic [RB_W-1:0] row_base_q, row_base_d;
    logic            line_seen_q, line_seen_d;

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        x_sub_d     = x_sub_q;
        y_sub_d     = y_sub_q;
        cell_x_d    = cell_x_q;
        cell_y_d    = cell_y_q;
        row_base_d  = row_base_q;
        line_seen_d = line_seen_q;

        if (i_pixel_valid) begin
            line_seen_d = 1'b1;
            if (x_sub_q == XS_W'(CELL_W - 1)) begin
                x_sub_d = '0;
                if (cell_x_q != CX_W'(GRID_W)) cell_x_d = cell_x_q + 1'b1;
            end else begin
                x_sub_d = x_sub_q + 1'b1;
            end
        end

        if (i_hsync) begin
            x_sub_d     = '0;
            cell_x_d    = '0;
            line_seen_d = 1'b0;
            if (line_seen_q || i_pixel_valid) begin
                if (y_sub_q == YS_W'(CELL_H - 1)) begin
                    y_sub_d = '0;
                    if (cell_y_q != CY_W'(GRID_H)) begin
                        cell_y_d   = cell_y_q + 1'b1;
                        row_base_d = row_base_q + RB_W'(GRID_W);
                    end
                end else begin
                    y_sub_d = y_sub_q + 1'b1;
                end
            end
        end

        if (i_vsync) begin
            x_sub_d     = '0;
            y_sub_d     = '0;
            cell_x_d    = '0;
            cell_y_d    = '0;
            row_base_d  = '0;
            line_seen_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            x_sub_q     <= '0;
            y_sub_q     <= '0;
            cell_x_q    <= '0;
            cell_y_q    <= '0;
            row_base_q  <= '0;
            line_seen_q <= 1'b0;
        end else begin
            x_sub_q     <= x_sub_d;
            y_sub_q     <= y_sub_d;
            cell_x_q    <= cell_x_d;
            cell_y_q    <= cell_y_d;
            row_base_q  <= row_base_d;
            line_seen_q <= line_seen_d;
        end
    end

    // ---------------- framebuffer ----------------
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [BPP-1:0]    ram_wdata;
    logic [ADDR_W-1:0] rd_addr;
    logic [BPP-1:0]    cell_rd;

    assign ram_we    = busy | pix_we;
    assign ram_waddr = busy ? clr_addr_q : ADDR_W'(cmd_index);
    assign ram_wdata = busy ? clr_val_q  : cmd_value;
    // Off-grid positions may alias other cells; the stage-1 flag masks them.
    assign rd_addr   = ADDR_W'(row_base_q + RB_W'(cell_x_q));

    cell_buffer_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (BPP),
        .ADDR_W (ADDR_W)
    ) u_cell_buffer_ram (
        .clk_i   (i_clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_addr),
        .rdata_o (cell_rd)
    );

    // ---------------- pixel pipeline ----------------
    logic    s1_valid_q, s1_oob_q;
    rgb444_t color_q, color_d;
    logic    color_valid_q, color_valid_d;

    always_comb begin
        color_d       = '0;
        color_valid_d = 1'b0;
        if (s1_valid_q) begin
            color_valid_d = 1'b1;
            if (s1_oob_q || cell_rd == '0) color_d = bg_q;
            else                           color_d = palette_q[cell_rd];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid_q    <= 1'b0;
            s1_oob_q      <= 1'b0;
            color_q       <= '0;
            color_valid_q <= 1'b0;
        end else begin
            s1_valid_q    <= i_pixel_valid;
            s1_oob_q      <= (cell_x_q >= CX_W'(GRID_W)) || (cell_y_q >= CY_W'(GRID_H));
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
        end
    end

    assign o_color       = color_q;
    assign o_color_valid = color_valid_q;
    assign o_busy        = busy;
    assign o_dropped     = dropped_q;

endmodule

// File: tb/tb_cell_pixel_generator.sv
// Directed bench for cell_pixel_generator at the default 40x30 grid of 16x16 cells, BPP=3.
module tb_cell_pixel_generator;

    localparam logic [7:0] OP_BG  = 8'h01;
    localparam logic [7:0] OP_PIX = 8'h07;
    localparam logic [7:0] OP_PAL = 8'h08;
    localparam logic [7:0] OP_CLR = 8'h09;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync, hsync, pix_valid;
    logic [31:0] instr;
    logic        ready;
    logic [11:0] color;
    logic        color_valid, busy, dropped;

    int checks = 0;
    int errors = 0;
    int n;

    logic [11:0] cap [0:1023];
    int          cap_n = 0;
    logic [11:0] pal_exp [8];

    cell_pixel_generator #(
        .GRID_W (40),
        .GRID_H (30),
        .CELL_W (16),
        .CELL_H (16),
        .BPP    (3)
    ) dut (
        .i_clk               (clk),
        .i_reset             (rst),
        .i_vsync             (vsync),
        .i_hsync             (hsync),
        .i_pixel_valid       (pix_valid),
        .i_instruction       (instr),
        .i_instruction_ready (ready),
        .o_color             (color),
        .o_color_valid       (color_valid),
        .o_busy              (busy),
        .o_dropped           (dropped)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (color_valid && cap_n < 1024) begin
            cap[cap_n] = color;
            cap_n = cap_n + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int lo, input int hi, input logic [11:0] exp);
        for (int i = lo; i <= hi; i++) begin
            chk($sformatf("%s x%0d", tag, i), 32'(cap[i]), 32'(exp));
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic [23:0] args);
        @(posedge clk); #1;
        instr = {args, op};
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        instr = '0;
    endtask

    task automatic count_drops(output int d);
        d = 0;
        repeat (4) begin
            @(negedge clk);
            if (dropped) d++;
        end
    endtask

    task automatic frame_start;
        @(posedge clk); #1 vsync = 1'b1;
        @(posedge clk); #1 vsync = 1'b0;
    endtask

    task automatic run_line(input int dots);
        cap_n = 0;
        for (int i = 0; i < dots; i++) begin
            @(posedge clk); #1 pix_valid = 1'b1;
        end
        @(posedge clk); #1 pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 hsync = 1'b1;
        @(posedge clk); #1 hsync = 1'b0;
    endtask

    initial begin
        int d;
        pal_exp = '{12'h000, 12'hfff, 12'hf00, 12'h0f0, 12'h00f, 12'hf0f, 12'h0ff, 12'hff0};
        rst = 1'b1; vsync = 1'b0; hsync = 1'b0; pix_valid = 1'b0; instr = '0; ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_color", 32'(color), 32'h000);
        chk("rst_valid", 32'(color_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dropped", 32'(dropped), 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // CLEAR 0: busy for exactly 40*30 cycles
        issue(OP_CLR, 24'h000000);
        n = 0;
        repeat (1500) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("clear_busy_cycles", 32'(n), 32'd1200);
        chk("clear_busy_end", 32'(busy), 32'h0);

        // Background fill
        issue(OP_BG, 24'h0000a5);
        frame_start();
        run_line(48);
        chk("bg_count", 32'(cap_n), 32'd48);
        check_range("bg_row0", 0, 47, 12'h0a5);
        @(negedge clk);
        chk("idle_color", 32'(color), 32'h000);
        chk("idle_valid", 32'(color_valid), 32'h0);

        // Cell 41 = 2 -> red on dots 16..31 of lines 16..31
        issue(OP_PIX, 24'h020029);
        count_drops(d);
        chk("pix41_nodrop", 32'(d), 32'd0);
        frame_start();
        run_line(48);
        check_range("c41_line0", 0, 47, 12'h0a5);
        repeat (15) run_line(1);
        run_line(48);
        chk("c41_l16_count", 32'(cap_n), 32'd48);
        check_range("c41_l16_left", 0, 15, 12'h0a5);
        check_range("c41_l16_cell", 16, 31, 12'hf00);
        check_range("c41_l16_right", 32, 47, 12'h0a5);

        // Palette change mid-frame applies immediately
        issue(OP_PAL, 24'h002123);
        run_line(48);
        check_range("pal_l17_left", 0, 15, 12'h0a5);
        check_range("pal_l17_cell", 16, 31, 12'h123);
        repeat (13) run_line(1);
        run_line(48);
        check_range("pal_l31_cell", 16, 31, 12'h123);
        check_range("pal_l31_right", 32, 47, 12'h0a5);
        run_line(48);
        check_range("row2_l32", 0, 47, 12'h0a5);

        // Background change waits for vsync
        issue(OP_BG, 24'h000fff);
        run_line(48);
        check_range("bg_old_l33", 0, 47, 12'h0a5);
        frame_start();
        run_line(48);
        check_range("bg_new_l0", 0, 47, 12'hfff);

        // Rejects: SET_PIXEL while clearing, then index out of range
        issue(OP_CLR, 24'h000000);
        issue(OP_PIX, 24'h040000);
        chk("busy_during_clear", 32'(busy), 32'h1);
        count_drops(d);
        chk("drop_busy", 32'(d), 32'd1);
        for (int i = 0; i < 1500 && busy; i++) @(negedge clk);
        chk("clear2_done", 32'(busy), 32'h0);
        issue(OP_PIX, 24'h0404b0);
        count_drops(d);
        chk("drop_range", 32'(d), 32'd1);
        issue(OP_PIX, 24'h0404af);
        count_drops(d);
        chk("edge_1199_nodrop", 32'(d), 32'd0);
        issue(OP_PIX, 24'h040028);

        frame_start();
        run_line(656);
        chk("wide_count", 32'(cap_n), 32'd656);
        check_range("drop_buf", 0, 15, 12'hfff);
        check_range("row0_rest", 16, 639, 12'hfff);
        check_range("oob_x", 640, 655, 12'hfff);
        repeat (463) run_line(1);
        run_line(640);
        check_range("l464_body", 0, 623, 12'hfff);
        check_range("l464_last", 624, 639, 12'h00f);
        repeat (14) run_line(1);
        run_line(640);
        check_range("l479_last", 624, 639, 12'h00f);
        run_line(16);
        chk("oob_y_count", 32'(cap_n), 32'd16);
        check_range("oob_y", 0, 15, 12'hfff);

        // Reset in the middle of a CLEAR sweep
        issue(OP_CLR, 24'h020000);
        @(posedge clk); #1 pix_valid = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'h1);
        chk("mid_valid", 32'(color_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_color", 32'(color), 32'h000);
        chk("abort_valid", 32'(color_valid), 32'h0);
        pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Palette defaults after reset: cells 0..7 hold values 0..7, bg is 000
        for (int i = 0; i < 8; i++) begin
            issue(OP_PIX, 24'((i << 16) | i));
        end
        frame_start();
        run_line(128);
        chk("paldef_count", 32'(cap_n), 32'd128);
        for (int i = 0; i < 8; i++) begin
            check_range($sformatf("paldef%0d", i), i * 16, i * 16 + 15, pal_exp[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
